sm4_req_scheduler: RTL and testbench

// Shares one SM4 core (key expansion + enc/dec datapath) between NREQ block requesters.
// - Round-robin arbitration between requesters; one operation in flight at a time.
// - Re-runs key expansion only when the granted {key, direction} differs from the loaded one.
// - Issues the block, waits for the result and returns it tagged with the requester id.

---
 rtl/sm4_req_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sm4_req_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_req_scheduler.sv
// sm4_req_scheduler: round-robin front end time-sharing one SM4 core,
// reloading the key schedule only when {key, direction} changes.
module sm4_req_scheduler #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 64,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_dec,
  input  logic [NREQ*128-1:0] req_key,
  input  logic [NREQ*128-1:0] req_data,
  input  logic              key_flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [127:0]      resp_data,
  output logic [IW-1:0]     resp_id,
  output logic              resp_err,
  output logic              sm4_enable,
  output logic              encdec_enable,
  output logic              encdec_sel,
  output logic              enable_key_exp,
  output logic              user_key_valid,
  output logic [127:0]      user_key,
  output logic              core_valid_in,
  output logic [127:0]      core_data_in,
  input  logic              key_exp_ready,
  input  logic              core_valid_out,
  input  logic [127:0]      core_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_KLOAD = 3'd2;
  localparam logic [2:0] S_KWAIT = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  typedef struct packed {
    logic [127:0]  key;
    logic [127:0]  data;
    logic          dec;
    logic [IW-1:0] id;
  } op_t;

  logic [2:0]    state;
  logic [IW-1:0] rr_ptr;
  logic          key_loaded;
  logic [127:0]  ld_key;
  logic          ld_dec;
  op_t           op;
  logic [CW-1:0] wcnt;
  logic [127:0]  rsp_data;
  logic          rsp_err;

  logic          gnt_hit;
  logic [IW-1:0] gnt_id;
  logic [127:0]  g_key;
  logic [127:0]  g_data;
  logic          g_dec;
  logic          key_hit;
  logic          wait_to;
  logic          in_key;

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] a,
    input int            b
  );
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // first valid requester at or after rr_ptr
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_hit && req_valid[wrap_inc(rr_ptr, k)]) begin
        gnt_hit = 1'b1;
        gnt_id  = wrap_inc(rr_ptr, k);
      end
    end
  end

  assign g_key  = req_key[128*int'(gnt_id) +: 128];
  assign g_data = req_data[128*int'(gnt_id) +: 128];
  assign g_dec  = req_dec[gnt_id];

  assign key_hit = key_loaded
                && (g_key == ld_key)
                && (g_dec == ld_dec);

  assign wait_to = (wcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      key_loaded <= 1'b0;
      ld_key     <= '0;
      ld_dec     <= 1'b0;
      op         <= '0;
      wcnt       <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) state <= S_ARB;
        end
        S_ARB: begin
          if (gnt_hit) begin
            op <= '{key: g_key, data: g_data,
                    dec: g_dec, id: gnt_id};
            rr_ptr <= wrap_inc(gnt_id, 1);
            state  <= key_hit ? S_ISSUE : S_KLOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_KLOAD: begin
          key_loaded <= 1'b0;
          wcnt       <= '0;
          state      <= S_KWAIT;
        end
        S_KWAIT: begin
          if (key_exp_ready) begin
            key_loaded <= 1'b1;
            ld_key     <= op.key;
            ld_dec     <= op.dec;
            state      <= S_ISSUE;
          end else if (wait_to) begin
            key_loaded <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_ISSUE: begin
          wcnt  <= '0;
          state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (core_valid_out) begin
            rsp_data <= core_result;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (wait_to) begin
            key_loaded <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= (|req_valid) ? S_ARB : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // flush overrides a same-cycle key_exp_ready
      if (key_flush) key_loaded <= 1'b0;
    end
  end

  assign in_key = (state == S_KLOAD) || (state == S_KWAIT);

  assign req_ready = (state == S_ARB && gnt_hit)
                   ? (NREQ'(1) << gnt_id) : '0;

  assign sm4_enable     = (state != S_IDLE);
  assign encdec_enable  = (state != S_IDLE);
  assign enable_key_exp = in_key;
  assign user_key_valid = (state == S_KLOAD);
  assign user_key       = in_key ? op.key : '0;
  assign encdec_sel     = in_key & op.dec;
  assign core_valid_in  = (state == S_ISSUE);
  assign core_data_in   = (state == S_ISSUE) ? op.data : '0;
  assign resp_valid     = (state == S_RESP);
  assign resp_data      = rsp_data;
  assign resp_id        = op.id;
  assign resp_err       = rsp_err;

endmodule

// File: tb/tb_sm4_req_scheduler.sv
// tb_sm4_req_scheduler: directed checks of the SM4 request scheduler
// against a behavioural core with fixed key-expansion and block latency.
module tb_sm4_req_scheduler;

  localparam int NREQ = 2;
  localparam int IW   = 1;
  localparam int TO   = 64;
  localparam int CLAT = 3;
  localparam int KLAT = 5;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] K2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E1  = 128'hfedcba98765432100123456789abcdef;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_dec = '0;
  logic [NREQ*128-1:0] req_key = '0;
  logic [NREQ*128-1:0] req_data = '0;
  logic key_flush = 1'b0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic [IW-1:0] resp_id;
  logic resp_err;
  logic sm4_enable, encdec_enable, encdec_sel;
  logic enable_key_exp, user_key_valid;
  logic [127:0] user_key;
  logic core_valid_in;
  logic [127:0] core_data_in;
  logic key_exp_ready;
  logic core_valid_out;
  logic [127:0] core_result;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm4_req_scheduler #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dec(req_dec), .req_key(req_key), .req_data(req_data),
    .key_flush(key_flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
    .sm4_enable(sm4_enable), .encdec_enable(encdec_enable),
    .encdec_sel(encdec_sel), .enable_key_exp(enable_key_exp),
    .user_key_valid(user_key_valid), .user_key(user_key),
    .core_valid_in(core_valid_in), .core_data_in(core_data_in),
    .key_exp_ready(key_exp_ready), .core_valid_out(core_valid_out),
    .core_result(core_result)
  );

  // stand-in core: knows the one SM4 test vector, otherwise a keyed mix
  function automatic logic [127:0] sm4_ref(
    input logic [127:0] k, input logic s, input logic [127:0] d
  );
    if (k == KEY && !s && d == CT) return 128'hbad;
    if (k == KEY && !s && d == PT) return CT;
    if (k == KEY && s && d == CT) return PT;
    return d ^ {k[63:0], k[127:64]} ^ {128{s}};
  endfunction

  logic [127:0] m_key = '0;
  logic m_sel = 1'b0;
  int kcnt = 0;
  logic kready = 1'b0;
  logic kexp_block = 1'b0;
  logic [CLAT-1:0] pipe = '0;
  logic [127:0] m_res = '0;
  int ukv_cnt = 0;

  always @(posedge clk) begin
    if (user_key_valid) begin
      m_key   <= user_key;
      m_sel   <= encdec_sel;
      kcnt    <= KLAT - 1;
      kready  <= 1'b0;
      ukv_cnt <= ukv_cnt + 1;
    end else if (kcnt > 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) kready <= 1'b1;
    end
    pipe <= {pipe[CLAT-2:0], core_valid_in};
    if (core_valid_in) m_res <= sm4_ref(m_key, m_sel, core_data_in);
  end

  assign key_exp_ready  = kready & ~kexp_block;
  assign core_valid_out = pipe[CLAT-1];
  assign core_result    = m_res;

  logic any_out;
  assign any_out = |{req_ready, resp_valid, resp_data, resp_id,
                     resp_err, sm4_enable, encdec_enable, encdec_sel,
                     enable_key_exp, user_key_valid, user_key,
                     core_valid_in, core_data_in};

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(
    input int id, input logic dec,
    input logic [127:0] key, input logic [127:0] data,
    input int hold, input int flush_at,
    output logic [127:0] rdata, output logic [IW-1:0] rid,
    output logic rerr, output int lat, output int pulses
  );
    bit ok;
    int c0;
    logic stable, nog;
    c0 = ukv_cnt;
    req_dec[id] = dec;
    req_key[128*id +: 128] = key;
    req_data[128*id +: 128] = data;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[id];
    end
    chk("grant", 128'(ok), 128'(1));
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i < 200 && !ok; i++) begin
      @(negedge clk);
      key_flush = (i == flush_at);
      if (resp_valid) begin
        ok  = 1'b1;
        lat = i;
      end
    end
    key_flush = 1'b0;
    chk("resp_seen", 128'(ok), 128'(1));
    rdata = resp_data;
    rid   = resp_id;
    rerr  = resp_err;
    stable = 1'b1;
    nog    = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== rdata ||
          resp_id !== rid || resp_err !== rerr) stable = 1'b0;
      if (req_ready != '0) nog = 1'b0;
    end
    if (hold > 0) begin
      chk("bp_stable", 128'(stable), 128'(1));
      chk("bp_nogrant", 128'(nog), 128'(1));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("resp_drop", 128'(resp_valid), 128'(0));
    pulses = ukv_cnt - c0;
  endtask

  logic [127:0] rd;
  logic [IW-1:0] ri;
  logic re;
  int lat, np;
  logic gnt_q [4];
  logic [IW-1:0] rid_q [4];
  logic [127:0] rdat_q [4];
  logic [127:0] fexp [4];
  int ng, nr;
  bit seen;
  logic bad;

  initial begin
    fexp[0] = CT; fexp[1] = E1; fexp[2] = CT; fexp[3] = E1;
    #1 chk("reset_outs", 128'(any_out), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // encrypt, first load of the key
    do_req(0, 1'b0, KEY, PT, 0, 0, rd, ri, re, lat, np);
    chk("enc_data", rd, CT);
    chk("enc_id", 128'(ri), 128'(0));
    chk("enc_err", 128'(re), 128'(0));
    chk("enc_kload", 128'(np), 128'(1));
    chk("enc_lat", 128'(lat), 128'(3 + KLAT + CLAT));

    // same key and direction: no reload
    do_req(0, 1'b0, KEY, PT, 0, 0, rd, ri, re, lat, np);
    chk("hit_data", rd, CT);
    chk("hit_kload", 128'(np), 128'(0));
    chk("hit_lat", 128'(lat), 128'(2 + CLAT));

    // direction change forces a reload with decrypt order
    do_req(0, 1'b1, KEY, CT, 0, 0, rd, ri, re, lat, np);
    chk("dec_data", rd, PT);
    chk("dec_kload", 128'(np), 128'(1));
    chk("dec_sel", 128'(m_sel), 128'(1));

    // fairness from a fresh pointer
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    req_key  = {KEY, KEY};
    req_dec  = 2'b00;
    req_data = {128'h0, PT};
    req_valid = 2'b11;
    resp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int i = 0; i < 300 && nr < 4; i++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 4) begin
        gnt_q[ng] = req_ready[1];
        ng++;
      end
      if (resp_valid) begin
        rid_q[nr]  = resp_id;
        rdat_q[nr] = resp_data;
        nr++;
        if (nr == 4) req_valid = 2'b00;
      end
    end
    @(posedge clk);
    #1 resp_ready = 1'b0;
    req_valid = 2'b00;
    chk("fair_count", 128'(nr), 128'(4));
    for (int k = 0; k < nr; k++) begin
      chk("fair_gnt", 128'(gnt_q[k]), 128'(k % 2));
      chk("fair_id", 128'(rid_q[k]), 128'(k % 2));
      chk("fair_data", rdat_q[k], fexp[k]);
    end

    // backpressure with req1 waiting behind req0
    req_key[255:128]  = KEY;
    req_data[255:128] = 128'h0;
    req_dec[1] = 1'b0;
    req_valid[1] = 1'b1;
    do_req(0, 1'b0, KEY, PT, 10, 0, rd, ri, re, lat, np);
    chk("bp_data", rd, CT);
    do_req(1, 1'b0, KEY, 128'h0, 0, 0, rd, ri, re, lat, np);
    chk("bp_next_id", 128'(ri), 128'(1));
    chk("bp_next_data", rd, E1);

    // flush in RWAIT: op completes, next identical request reloads
    do_req(0, 1'b0, KEY, PT, 0, 2, rd, ri, re, lat, np);
    chk("fl_data", rd, CT);
    chk("fl_kload", 128'(np), 128'(0));
    do_req(0, 1'b0, KEY, PT, 0, 0, rd, ri, re, lat, np);
    chk("fl_reload", 128'(np), 128'(1));
    chk("fl_lat", 128'(lat), 128'(3 + KLAT + CLAT));

    // key expansion never completes
    kexp_block = 1'b1;
    do_req(0, 1'b0, K2, PT, 0, 0, rd, ri, re, lat, np);
    chk("to_err", 128'(re), 128'(1));
    chk("to_data", rd, 128'h0);
    chk("to_lat", 128'(lat >= TO && lat <= TO + 4), 128'(1));
    kexp_block = 1'b0;

    // asynchronous reset while waiting for the core
    req_key[127:0]  = K2;
    req_data[127:0] = PT;
    req_dec[0] = 1'b0;
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = core_valid_in;
    end
    chk("rst_issue", 128'(seen), 128'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    req_valid = '0;
    #1 chk("rst_async", 128'(any_out), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid || sm4_enable) bad = 1'b1;
    end
    chk("rst_discard", 128'(bad), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
